// File: rtl/cmd_frame_resp.sv
// cmd_frame_resp: assembles UART byte pairs into 16-bit commands and
// feeds single-byte responses to the UART transmitter through a one-deep buffer.
module cmd_frame_resp #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        tx_trmt,
  input  logic        uart_tx_done,
  output logic        resp_sent,
  output logic        resp_drop
);
  typedef enum logic {WAIT_HI, WAIT_LO} rx_st_t;
  typedef enum logic {IDLE, SEND} tx_st_t;
  rx_st_t rx_st_q, rx_st_d;
  tx_st_t tx_st_q, tx_st_d;
  logic [7:0] hi_q, hi_d, pend_data_q, pend_data_d, tx_data_q, tx_data_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic clr_rx_rdy_q, clr_rx_rdy_d, cmd_rdy_q, cmd_rdy_d, overrun_q, overrun_d;
  logic pend_vld_q, pend_vld_d, tx_trmt_q, tx_trmt_d, resp_sent_q, resp_sent_d;
  logic resp_drop_q, resp_drop_d, accept;
  // rx_rdy stays high through the clr_rx_rdy cycle, so that cycle must not count
  assign accept = rx_rdy & ~clr_rx_rdy_q;
  assign clr_rx_rdy_d = accept;
  always_comb begin
    rx_st_d = rx_st_q;
    hi_d = hi_q;
    to_cnt_d = to_cnt_q;
    cmd_d = cmd_q;
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    overrun_d = overrun_q & ~clr_cmd_rdy;
    if (rx_st_q == WAIT_HI) begin
      if (accept) begin
        hi_d = rx_data;
        to_cnt_d = '0;
        rx_st_d = WAIT_LO;
      end
    end else if (accept) begin
      rx_st_d = WAIT_HI;
      if (!cmd_rdy_q || clr_cmd_rdy) begin
        cmd_d = {hi_q, rx_data};
        cmd_rdy_d = 1'b1;
      end else overrun_d = 1'b1;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) rx_st_d = WAIT_HI;
    else to_cnt_d = to_cnt_q + TO_W'(1);
  end
  always_comb begin
    tx_st_d = tx_st_q;
    pend_vld_d = pend_vld_q;
    pend_data_d = pend_data_q;
    tx_data_d = tx_data_q;
    tx_trmt_d = 1'b0;
    resp_sent_d = 1'b0;
    resp_drop_d = resp_drop_q;
    if (tx_st_q == IDLE) begin
      if (pend_vld_q || send_resp) begin
        tx_data_d = pend_vld_q ? pend_data_q : resp;
        tx_trmt_d = 1'b1;
        tx_st_d = SEND;
        pend_vld_d = pend_vld_q & send_resp;
        pend_data_d = send_resp ? resp : pend_data_q;
      end
    end else begin
      if (send_resp) begin
        if (pend_vld_q) resp_drop_d = 1'b1;
        else begin
          pend_vld_d = 1'b1;
          pend_data_d = resp;
        end
      end
      if (uart_tx_done) begin
        resp_sent_d = 1'b1;
        tx_st_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q <= WAIT_HI;
      tx_st_q <= IDLE;
      hi_q <= '0;
      to_cnt_q <= '0;
      cmd_q <= '0;
      clr_rx_rdy_q <= 1'b0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_data_q <= '0;
      tx_data_q <= '0;
      tx_trmt_q <= 1'b0;
      resp_sent_q <= 1'b0;
      resp_drop_q <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      tx_st_q <= tx_st_d;
      hi_q <= hi_d;
      to_cnt_q <= to_cnt_d;
      cmd_q <= cmd_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      pend_vld_q <= pend_vld_d;
      pend_data_q <= pend_data_d;
      tx_data_q <= tx_data_d;
      tx_trmt_q <= tx_trmt_d;
      resp_sent_q <= resp_sent_d;
      resp_drop_q <= resp_drop_d;
    end
  end
  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign overrun = overrun_q;
  assign tx_data = tx_data_q;
  assign tx_trmt = tx_trmt_q;
  assign resp_sent = resp_sent_q;
  assign resp_drop = resp_drop_q;
endmodule

// File: doc/cmd_frame_resp.md
Name: cmd_frame_resp

Overview:
Knight-side endpoint of the remote command link. It consumes bytes from the UART receiver core and assembles each high-byte/low-byte pair from the remote unit into a 16-bit command for cmd_proc, using a cmd_rdy/clr_cmd_rdy handshake. In the other direction it accepts 8-bit responses from cmd_proc (for example 0xA5 on completion) and drives them into the UART transmitter core, holding one response in a buffer while a byte is in flight. It sits between the UART_rx/UART_tx cores and cmd_proc.

Parameters:
TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between the high byte and the low byte before the partial frame is discarded.
TO_W, 17, width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous reset, active-high.
rx_data  in  8  byte from the UART receiver.
rx_rdy  in  1  level from the UART receiver: a byte is valid. Stays high until the cycle after clr_rx_rdy.
clr_rx_rdy  out  1  one-cycle pulse that consumes rx_data.
cmd  out  16  assembled command, {high byte, low byte}.
cmd_rdy  out  1  level: cmd is valid.
clr_cmd_rdy  in  1  from cmd_proc: clears cmd_rdy.
overrun  out  1  sticky: a completed frame was discarded because cmd_rdy was still set.
resp  in  8  response byte from cmd_proc.
send_resp  in  1  one-cycle request to transmit resp.
tx_data  out  8  byte to the UART transmitter.
tx_trmt  out  1  one-cycle start pulse to the UART transmitter.
uart_tx_done  in  1  one-cycle pulse from the UART transmitter at the end of the stop bit.
resp_sent  out  1  one-cycle pulse when a response byte has finished transmitting.
resp_drop  out  1  sticky: a send_resp was lost because the buffer was full.

Behaviour:
- Reset values: all outputs 0; cmd = 0x0000; tx_data = 0x00; both FSMs in IDLE; timeout counter 0; response buffer empty.
- Byte accept: a byte is taken in a cycle where rx_rdy=1 and clr_rx_rdy=0. clr_rx_rdy pulses in the next cycle, so each byte is counted exactly once.
- RX FSM has two states, WAIT_HI and WAIT_LO.
  - WAIT_HI: on byte accept, latch the byte as the high byte, clear the timeout counter, and go to WAIT_LO.
  - WAIT_LO: the counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 with no byte, discard the high byte and return to WAIT_HI; cmd and cmd_rdy are untouched.
  - WAIT_LO, byte accepted:
    - If cmd_rdy=0: on the next edge cmd = {hi, byte} and cmd_rdy = 1.
    - If cmd_rdy=1 and clr_cmd_rdy=0: keep the old cmd and set overrun.
    - Either way, return to WAIT_HI.
- Latency: cmd_rdy rises 1 clock after the low byte is accepted.
- Handshake: clr_cmd_rdy clears cmd_rdy on the next edge and also clears overrun. If clr_cmd_rdy coincides with a frame completing, the new frame wins: cmd updates and cmd_rdy stays 1.
- cmd holds its value until the next accepted frame.
- TX FSM has two states, IDLE and SEND. The response buffer is one entry deep: pend_vld plus pend_data.
  - IDLE: if send_resp=1, or pend_vld=1, then on the next edge tx_data = the byte, tx_trmt pulses for 1 cycle, and the FSM enters SEND.
    - When both are present, pend_data goes first and the new resp goes into the buffer.
  - SEND: on uart_tx_done, pulse resp_sent in the next cycle and return to IDLE. A pending byte starts in the cycle after IDLE is re-entered.
  - SEND with send_resp=1: if pend_vld=0, buffer resp. If the buffer is full, drop resp and set resp_drop, which clears only on rst.
  - send_resp and uart_tx_done in the same cycle in SEND: buffer resp first; no drop occurs if the buffer was empty.
- The RX and TX paths are fully independent; simultaneous activity on both is legal.
- rst asserted mid-frame or mid-send: both FSMs return to IDLE/WAIT_HI immediately. The partial high byte and the pending response are lost. No tx_trmt is issued after reset is released unless send_resp is seen.

Test Plan:
- Bytes 0x30 then 0x01 -> cmd = 0x3001, cmd_rdy = 1 one clock after the low byte; exactly two clr_rx_rdy pulses; clr_cmd_rdy -> cmd_rdy = 0.
- Byte 0x20, then no byte for TIMEOUT_CYCLES clocks, then bytes 0x00 and 0x00 -> cmd = 0x0000, never 0x2000.
- Frame 0x4002 with cmd_rdy held, then frame 0x5003 -> cmd stays 0x4002, overrun = 1; clr_cmd_rdy clears both; a following 0x5003 is then accepted.
- send_resp with resp = 0xA5 while idle -> tx_trmt pulse with tx_data = 0xA5; uart_tx_done -> resp_sent pulse 1 cycle later.
- Three send_resp (0xA5, 0x5A, 0x11) during one transmission -> 0xA5 sent, 0x5A sent next, 0x11 dropped with resp_drop = 1.
- rst asserted after the high byte 0x30 and during a send -> all outputs 0; a new frame 0x0000 is then assembled correctly.
